// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the slave FSM state encodings.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_WAIT_W = 2'd1,
        W_WAIT_A = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Byte-strobed register array: one write port, one asynchronous read port,
// and every register exposed on a flattened output bus.
module axi_lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                           ACLK,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [IDX_WIDTH-1:0]           wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [IDX_WIDTH-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Storage: clear everything on reset, otherwise update only the strobed bytes.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem[k];
    end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave over a small word-indexed register file. Write address and
// write data are accepted independently in either order; reads run on their
// own FSM. Register contents and per-register write pulses go to the datapath.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;

    logic                  commit;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_WIDTH-1:0] commit_strb;
    logic                  commit_in_range;
    logic [IDX_WIDTH-1:0]  commit_idx;

    logic                  awready_next, wready_next, bvalid_next;
    logic                  arready_next, rvalid_next;

    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] rd_data;

    // PROT carries no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    assign commit_in_range = ({1'b0, commit_addr} < NUM_REGS_LIMIT);
    assign commit_idx      = commit_addr[IDX_WIDTH-1:0];
    assign ar_in_range     = ({1'b0, ARADDR} < NUM_REGS_LIMIT);

    // Write FSM and ready/valid flops; outputs come from the decoded next state.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            wr_state <= W_IDLE;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            BVALID   <= 1'b0;
        end else begin
            wr_state <= wr_state_next;
            AWREADY  <= awready_next;
            WREADY   <= wready_next;
            BVALID   <= bvalid_next;
        end
    end

    // Write next state, and which address/data/strobe commit when the pair completes.
    always_comb begin
        wr_state_next = wr_state;
        commit        = 1'b0;
        commit_addr   = addr_q;
        commit_data   = data_q;
        commit_strb   = strb_q;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit        = 1'b1;
                    commit_addr   = AWADDR;
                    commit_data   = WDATA;
                    commit_strb   = WSTRB;
                    wr_state_next = W_RESP;
                end else if (aw_hs) begin
                    wr_state_next = W_WAIT_W;
                end else if (w_hs) begin
                    wr_state_next = W_WAIT_A;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    commit        = 1'b1;
                    commit_data   = WDATA;
                    commit_strb   = WSTRB;
                    wr_state_next = W_RESP;
                end
            end
            W_WAIT_A: begin
                if (aw_hs) begin
                    commit        = 1'b1;
                    commit_addr   = AWADDR;
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) begin
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Write channel ready/valid values for the state being entered.
    always_comb begin
        awready_next = (wr_state_next == W_IDLE) || (wr_state_next == W_WAIT_A);
        wready_next  = (wr_state_next == W_IDLE) || (wr_state_next == W_WAIT_W);
        bvalid_next  = (wr_state_next == W_RESP);
    end

    // Hold whichever half of a write arrives first, plus the response and pulse.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            BRESP    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            if (aw_hs) begin
                addr_q <= AWADDR;
            end
            if (w_hs) begin
                data_q <= WDATA;
                strb_q <= WSTRB;
            end
            if (commit) begin
                BRESP <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (commit && commit_in_range) begin
                wr_pulse <= NUM_REGS'(1) << commit_idx;
            end else begin
                wr_pulse <= '0;
            end
        end
    end

    // Read FSM and its ready/valid flops.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            rd_state <= R_IDLE;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
        end else begin
            rd_state <= rd_state_next;
            ARREADY  <= arready_next;
            RVALID   <= rvalid_next;
        end
    end

    // Read next state: one outstanding read, released by RREADY.
    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
            R_DATA:  if (RVALID && RREADY) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read channel ready/valid values for the state being entered.
    always_comb begin
        arready_next = (rd_state_next == R_IDLE);
        rvalid_next  = (rd_state_next == R_DATA);
    end

    // Capture read data at the AR handshake; the array still holds pre-write contents.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            RDATA <= ar_in_range ? rd_data : '0;
            RRESP <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axi_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .ACLK      (ACLK),
        .reset     (reset),
        .wr_en     (commit && commit_in_range),
        .wr_idx    (commit_idx),
        .wr_data   (commit_data),
        .wr_strb   (commit_strb),
        .rd_idx    (ARADDR[IDX_WIDTH-1:0]),
        .rd_data   (rd_data),
        .regs_flat (regs_o)
    );

endmodule
